// File: rtl/qam_symbol_packer.sv
// rtl/qam_symbol_packer.sv - packs 2-bit QAM symbols into framed Avalon-ST words
// One symbol per clock in, one registered word out; backpressure stalls the sink.
module qam_symbol_packer #(
  parameter int SYMS_PER_WORD = 4,
  parameter int EW            = 2
) (
  input  logic                         clock_clk,
  input  logic                         reset_reset_n,
  input  logic [1:0]                   asi_in0_data,
  input  logic                         asi_in0_valid,
  output logic                         asi_in0_ready,
  input  logic                         asi_in0_startofpacket,
  input  logic                         asi_in0_endofpacket,
  output logic [2*SYMS_PER_WORD-1:0]   aso_out0_data,
  output logic                         aso_out0_valid,
  input  logic                         aso_out0_ready,
  output logic                         aso_out0_startofpacket,
  output logic                         aso_out0_endofpacket,
  output logic [EW-1:0]                aso_out0_empty,
  output logic                         err_sop_drop
);

  localparam int W = 2 * SYMS_PER_WORD;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;
  localparam logic [EW-1:0] LAST_SLOT = EW'(SYMS_PER_WORD - 1);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          sop_pending_q, sop_pending_d;
  logic [W-1:0]  hold_data_q, hold_data_d;
  logic          hold_valid_q, hold_valid_d;
  logic          hold_sop_q, hold_sop_d;
  logic          hold_eop_q, hold_eop_d;
  logic [EW-1:0] hold_empty_q, hold_empty_d;
  logic          err_q, err_d;

  logic          accept;
  logic          take;
  logic          done;
  logic [EW-1:0] slot;
  logic [W-1:0]  merged;

  assign asi_in0_ready = !hold_valid_q || aso_out0_ready;

  always_comb begin
    accept = asi_in0_valid && asi_in0_ready;
    // Outside a packet only a sop symbol is worth keeping.
    take   = accept && ((state_q == ST_PACK) || asi_in0_startofpacket);
    slot   = asi_in0_startofpacket ? '0 : cnt_q;
    merged = asi_in0_startofpacket ? '0 : acc_q;
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (slot == EW'(i)) begin
        merged[W-1-2*i -: 2] = asi_in0_data;
      end
    end
    done = asi_in0_endofpacket || (slot == LAST_SLOT);

    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sop_pending_d = sop_pending_q;
    hold_data_d   = hold_data_q;
    hold_valid_d  = hold_valid_q;
    hold_sop_d    = hold_sop_q;
    hold_eop_d    = hold_eop_q;
    hold_empty_d  = hold_empty_q;
    err_d         = 1'b0;

    if (hold_valid_q && aso_out0_ready) begin
      hold_valid_d = 1'b0;
    end

    if (take) begin
      if (asi_in0_startofpacket && (state_q == ST_PACK) && (cnt_q != '0)) begin
        err_d = 1'b1;
      end
      if (done) begin
        // acc is kept zero beyond cnt, so unfilled slots come out as padding.
        hold_data_d   = merged;
        hold_valid_d  = 1'b1;
        hold_sop_d    = asi_in0_startofpacket || sop_pending_q;
        hold_eop_d    = asi_in0_endofpacket;
        hold_empty_d  = asi_in0_endofpacket ? (LAST_SLOT - slot) : '0;
        sop_pending_d = 1'b0;
        acc_d         = '0;
        cnt_d         = '0;
        state_d       = asi_in0_endofpacket ? ST_IDLE : ST_PACK;
      end else begin
        acc_d         = merged;
        cnt_d         = slot + EW'(1);
        sop_pending_d = asi_in0_startofpacket || sop_pending_q;
        state_d       = ST_PACK;
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      sop_pending_q <= 1'b0;
      hold_data_q   <= '0;
      hold_valid_q  <= 1'b0;
      hold_sop_q    <= 1'b0;
      hold_eop_q    <= 1'b0;
      hold_empty_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sop_pending_q <= sop_pending_d;
      hold_data_q   <= hold_data_d;
      hold_valid_q  <= hold_valid_d;
      hold_sop_q    <= hold_sop_d;
      hold_eop_q    <= hold_eop_d;
      hold_empty_q  <= hold_empty_d;
      err_q         <= err_d;
    end
  end

  assign aso_out0_data          = hold_data_q;
  assign aso_out0_valid         = hold_valid_q;
  assign aso_out0_startofpacket = hold_sop_q;
  assign aso_out0_endofpacket   = hold_eop_q;
  assign aso_out0_empty         = hold_empty_q;
  assign err_sop_drop           = err_q;

endmodule
